// File: rtl/pwm_out_stage_if.sv
// pwm_out_stage_if: control/status bundle between the PWM output stage and its
// upstream PIO register block.
interface pwm_out_stage_if;
  localparam int unsigned DW = 11;

  logic          enable;
  logic [DW-1:0] duty_in;
  logic          pwm_out;
  logic          period_start;
  logic [DW-1:0] duty_active;

  // Upstream register block drives the requests and observes the waveform
  modport master (
    output enable,
    output duty_in,
    input  pwm_out,
    input  period_start,
    input  duty_active
  );

  // PWM stage consumes the requests and drives the waveform
  modport slave (
    input  enable,
    input  duty_in,
    output pwm_out,
    output period_start,
    output duty_active
  );
endinterface

// File: rtl/pwm_out_stage.sv
// pwm_out_stage: fixed-period PWM generator with glitch-free duty update at
// period boundaries. Optional duty slew limiting is compiled in when the macro
// PWM_SLEW_EN is defined; the default build loads the clamped duty directly.
module pwm_out_stage #(
  parameter int unsigned PERIOD    = 2000,
  parameter int unsigned SLEW_STEP = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  pwm_out_stage_if.slave  bus
);
  localparam int unsigned CW = 11;
  localparam int unsigned XW = CW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD - 1);
  // PERIOD may be 2048, which needs one bit more than the duty/count width
  localparam logic [XW-1:0] PERIOD_X = XW'(PERIOD);

  // Reject illegal configurations at elaboration
  if (PERIOD < 2 || PERIOD > 2048 || SLEW_STEP < 1 || SLEW_STEP > 2047) begin : g_bad_cfg
    $error("pwm_out_stage: PERIOD or SLEW_STEP out of range");
  end

  logic [CW-1:0] r_cnt;
  logic          r_pwm;
  logic          r_ps;
  logic [CW-1:0] r_duty;

  logic [CW-1:0] w_cnt_nxt;
  logic          w_pwm_nxt;
  logic          w_ps_nxt;
  logic [CW-1:0] w_duty_nxt;
  logic          w_wrap;
  logic [CW-1:0] w_clamp;
  logic [CW-1:0] w_wrap_duty;
  logic [CW-1:0] w_idle_duty;

  assign w_wrap  = (r_cnt == LAST_CNT);
  // Clamp request to the period; never taken when PERIOD exceeds the duty range
  assign w_clamp = ({1'b0, bus.duty_in} > PERIOD_X) ? CW'(PERIOD_X) : bus.duty_in;

`ifdef PWM_SLEW_EN
  logic          w_up;
  logic [CW-1:0] w_diff;
  logic [CW-1:0] w_stepv;

  // Move toward the target by at most SLEW_STEP per period; idle restarts from zero
  assign w_up        = (w_clamp > r_duty);
  assign w_diff      = w_up ? (w_clamp - r_duty) : (r_duty - w_clamp);
  assign w_stepv     = ({1'b0, w_diff} > XW'(SLEW_STEP)) ? CW'(SLEW_STEP) : w_diff;
  assign w_wrap_duty = w_up ? (r_duty + w_stepv) : (r_duty - w_stepv);
  assign w_idle_duty = '0;
`else
  assign w_wrap_duty = w_clamp;
  assign w_idle_duty = w_clamp;
`endif

  // Next-state: idle holds the counter at zero, run mode counts and latches duty at wrap
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_pwm_nxt  = 1'b0;
    w_ps_nxt   = 1'b0;
    w_duty_nxt = r_duty;
    if (!bus.enable) begin
      w_cnt_nxt  = '0;
      w_duty_nxt = w_idle_duty;
    end else begin
      w_cnt_nxt = w_wrap ? '0 : (r_cnt + CW'(1));
      w_pwm_nxt = (r_cnt < r_duty);
      w_ps_nxt  = w_wrap;
      if (w_wrap) begin
        w_duty_nxt = w_wrap_duty;
      end
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_pwm  <= 1'b0;
      r_ps   <= 1'b0;
      r_duty <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_pwm  <= w_pwm_nxt;
      r_ps   <= w_ps_nxt;
      r_duty <= w_duty_nxt;
    end
  end

  assign bus.pwm_out      = r_pwm;
  assign bus.period_start = r_ps;
  assign bus.duty_active  = r_duty;
endmodule

// File: tb/tb_pwm_out_stage.sv
// tb_pwm_out_stage: directed scenarios with a cycle-position model of the PWM
// stage checked every cycle, plus literal window counts for each scenario.
module tb_pwm_out_stage;
  localparam int PERIOD    = 2000;
  localparam int SLEW_STEP = 16;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  pwm_out_stage_if bus ();

  pwm_out_stage #(
    .PERIOD    (PERIOD),
    .SLEW_STEP (SLEW_STEP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: m_k counts enabled edges since the last idle/reset; position = m_k mod PERIOD
  int m_k    = 0;
  int e_pwm  = 0;
  int e_ps   = 0;
  int e_duty = 0;

  function automatic int clamp_f(input int d);
    return (d > PERIOD) ? PERIOD : d;
  endfunction

  function automatic int wrap_duty(input int cur, input int din);
    int t;
    t = clamp_f(din);
`ifdef PWM_SLEW_EN
    if (t > cur) return cur + (((t - cur) > SLEW_STEP) ? SLEW_STEP : (t - cur));
    return cur - (((cur - t) > SLEW_STEP) ? SLEW_STEP : (cur - t));
`else
    return t + 0 * cur;
`endif
  endfunction

  function automatic int idle_duty(input int din);
`ifdef PWM_SLEW_EN
    return 0 * din;
`else
    return clamp_f(din);
`endif
  endfunction

  // Model update on the same edges as the DUT
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_k    <= 0;
      e_pwm  <= 0;
      e_ps   <= 0;
      e_duty <= 0;
    end else if (!bus.enable) begin
      m_k    <= 0;
      e_pwm  <= 0;
      e_ps   <= 0;
      e_duty <= idle_duty(int'(bus.duty_in));
    end else begin
      e_pwm <= ((m_k % PERIOD) < e_duty) ? 1 : 0;
      e_ps  <= ((m_k % PERIOD) == PERIOD - 1) ? 1 : 0;
      if ((m_k % PERIOD) == PERIOD - 1) e_duty <= wrap_duty(e_duty, int'(bus.duty_in));
      m_k <= m_k + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and compare all outputs against the model
  task automatic step();
    @(negedge clk);
    check("model pwm_out", int'(bus.pwm_out), e_pwm);
    check("model period_start", int'(bus.period_start), e_ps);
    check("model duty_active", int'(bus.duty_active), e_duty);
  endtask

  task automatic window(input int n, output int hi, output int ps);
    hi = 0;
    ps = 0;
    repeat (n) begin
      step();
      hi += int'(bus.pwm_out);
      ps += int'(bus.period_start);
    end
  endtask

  int hi, ps;

  initial begin
    reset_n      = 1'b0;
    bus.enable   = 1'b0;
    bus.duty_in  = 11'd0;
    repeat (3) @(negedge clk);
    check("reset pwm_out", int'(bus.pwm_out), 0);
    check("reset period_start", int'(bus.period_start), 0);
    check("reset duty_active", int'(bus.duty_active), 0);

    // Steady 500/2000 duty
    reset_n     = 1'b1;
    bus.duty_in = 11'd500;
    step();
`ifndef PWM_SLEW_EN
    check("idle load duty_active", int'(bus.duty_active), 500);
`endif
    bus.enable = 1'b1;
    window(PERIOD, hi, ps);
    check("duty500 p1 high", hi, 500);
    check("duty500 p1 starts", ps, 1);
    window(PERIOD, hi, ps);
    check("duty500 p2 high", hi, 500);
    check("duty500 p2 starts", ps, 1);

    // Mid-period duty change takes effect at the next boundary only
    window(100, hi, ps);
    bus.duty_in = 11'd1500;
    window(PERIOD - 101, hi, ps);
    check("midchange held duty", int'(bus.duty_active), 500);
    step();
`ifndef PWM_SLEW_EN
    check("midchange new duty", int'(bus.duty_active), 1500);
`endif
    window(PERIOD, hi, ps);
`ifndef PWM_SLEW_EN
    check("duty1500 high", hi, 1500);
`endif
    check("duty1500 starts", ps, 1);

    // Boundary duties: 0, PERIOD, above PERIOD
    bus.duty_in = 11'd0;
    window(PERIOD, hi, ps);
    window(PERIOD, hi, ps);
`ifndef PWM_SLEW_EN
    check("duty0 high", hi, 0);
    bus.duty_in = 11'd2000;
    window(PERIOD, hi, ps);
    window(PERIOD, hi, ps);
    check("duty2000 high", hi, 2000);
    check("duty2000 starts", ps, 1);
    bus.duty_in = 11'd2047;
    window(PERIOD, hi, ps);
    check("duty2047 clamped", int'(bus.duty_active), 2000);
    window(PERIOD, hi, ps);
    check("duty2047 high", hi, 2000);
`endif

    // Disable mid-period, then re-enable
    bus.duty_in = 11'd1000;
    window(PERIOD, hi, ps);
    window(300, hi, ps);
`ifndef PWM_SLEW_EN
    check("pre-disable pwm", int'(bus.pwm_out), 1);
`endif
    bus.enable = 1'b0;
    step();
    check("disable pwm low", int'(bus.pwm_out), 0);
    check("disable no start", int'(bus.period_start), 0);
    window(5, hi, ps);
    bus.enable = 1'b1;
    step();
`ifndef PWM_SLEW_EN
    check("reenable pwm high", int'(bus.pwm_out), 1);
`endif
    check("reenable no start", int'(bus.period_start), 0);
    window(PERIOD - 2, hi, ps);
    check("reenable early starts", ps, 0);
    step();
    check("reenable first wrap", int'(bus.period_start), 1);

    // Asynchronous reset pulse mid-period
    window(500, hi, ps);
    #2 reset_n = 1'b0;
    #1;
    check("async pwm_out", int'(bus.pwm_out), 0);
    check("async period_start", int'(bus.period_start), 0);
    check("async duty_active", int'(bus.duty_active), 0);
    #1 reset_n = 1'b1;
    window(PERIOD, hi, ps);
    check("post-reset period high", hi, 0);
    check("post-reset starts", ps, 1);

`ifdef PWM_SLEW_EN
    begin
      int exp_seq [6] = '{16, 32, 40, 24, 8, 0};
      bus.enable  = 1'b0;
      bus.duty_in = 11'd40;
      window(3, hi, ps);
      check("slew idle duty", int'(bus.duty_active), 0);
      bus.enable = 1'b1;
      step();
      check("slew start duty", int'(bus.duty_active), 0);
      for (int i = 0; i < 6; i++) begin
        window((i == 0) ? PERIOD - 1 : PERIOD, hi, ps);
        check("slew ramp duty", int'(bus.duty_active), exp_seq[i]);
        if (i == 2) bus.duty_in = 11'd0;
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
